// File: rtl/tmds_link_ctrl_pkg.sv
// Shared definitions for the TMDS link sequencer:
// control tokens, symbol type, state encoding.
package tmds_link_ctrl_pkg;

    localparam int SYM_W = 10;

    typedef logic [SYM_W-1:0] sym_t;

    localparam sym_t CTRL_00 = 10'b1101010100;
    localparam sym_t CTRL_01 = 10'b0010101011;
    localparam sym_t CTRL_10 = 10'b0101010100;
    localparam sym_t CTRL_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RST_HOLD  = 2'd1,
        FLUSH     = 2'd2,
        ACTIVE    = 2'd3
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tmds_link_ctrl_if.sv
// Symbol bus between encoders, the link sequencer
// and the serializers.
interface tmds_link_ctrl_if;
    import tmds_link_ctrl_pkg::*;

    sym_t i_tmds_ch0;
    sym_t i_tmds_ch1;
    sym_t i_tmds_ch2;
    sym_t o_pdata_ch0;
    sym_t o_pdata_ch1;
    sym_t o_pdata_ch2;
    logic o_timing_en;

    modport master (
        output i_tmds_ch0, i_tmds_ch1, i_tmds_ch2,
        input  o_pdata_ch0, o_pdata_ch1, o_pdata_ch2,
        input  o_timing_en
    );

    modport slave (
        input  i_tmds_ch0, i_tmds_ch1, i_tmds_ch2,
        output o_pdata_ch0, o_pdata_ch1, o_pdata_ch2,
        output o_timing_en
    );

endinterface

// File: rtl/tmds_link_ctrl_sync_2ff.sv
// Two-flop synchronizer with a parameterised
// reset value.
module tmds_link_ctrl_sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/tmds_link_ctrl.sv
// Bring-up / teardown sequencer for the three
// TMDS serializer channels.
module tmds_link_ctrl
    import tmds_link_ctrl_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int FLUSH_CYCLES       = 1650
) (
    input  logic              i_pdata_clk,
    input  logic              i_rst,
    input  logic              i_pll_locked,
    input  logic              i_link_en,
    tmds_link_ctrl_if.slave   io_link,
    output logic              o_serdes_rst,
    output logic              o_link_up,
    output logic [1:0]        o_state
);

    localparam int CW = $clog2(max3(LOCK_STABLE_CYCLES,
                                    RST_HOLD_CYCLES,
                                    FLUSH_CYCLES)) + 1;

    localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYCLES - 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            w_lock_s;
    logic            w_go;

    tmds_link_ctrl_sync_2ff #(
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .i_clk (i_pdata_clk),
        .i_rst (i_rst),
        .i_d   (i_pll_locked),
        .o_q   (w_lock_s)
    );

    assign w_go    = w_lock_s & i_link_en;
    assign o_state = r_state;

    // Losing the go condition anywhere looks exactly like
    // reset; in WAIT_LOCK it just restarts qualification.
    always_ff @(posedge i_pdata_clk) begin
        if (i_rst || !w_go) begin
            r_state             <= WAIT_LOCK;
            r_cnt               <= '0;
            o_serdes_rst        <= 1'b1;
            io_link.o_pdata_ch0 <= CTRL_00;
            io_link.o_pdata_ch1 <= CTRL_00;
            io_link.o_pdata_ch2 <= CTRL_00;
            io_link.o_timing_en <= 1'b0;
            o_link_up           <= 1'b0;
        end else begin
            unique case (r_state)
                WAIT_LOCK: begin
                    if (r_cnt == LOCK_LAST) begin
                        r_state <= RST_HOLD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state      <= FLUSH;
                        r_cnt        <= '0;
                        o_serdes_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                FLUSH: begin
                    if (r_cnt == FLUSH_LAST) begin
                        r_state             <= ACTIVE;
                        r_cnt               <= '0;
                        io_link.o_timing_en <= 1'b1;
                        o_link_up           <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ACTIVE: begin
                    io_link.o_pdata_ch0 <= io_link.i_tmds_ch0;
                    io_link.o_pdata_ch1 <= io_link.i_tmds_ch1;
                    io_link.o_pdata_ch2 <= io_link.i_tmds_ch2;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmds_link_ctrl.sv
// Self-checking bench for tmds_link_ctrl: directed table,
// corner sequences and randomized run against a phase model.
module tb_tmds_link_ctrl;
    import tmds_link_ctrl_pkg::*;

    localparam int L = 8;
    localparam int H = 4;
    localparam int F = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       lock;
    logic       en;
    logic       srst;
    logic       link;
    logic [1:0] st;

    always #5 clk = ~clk;

    tmds_link_ctrl_if u_if();

    tmds_link_ctrl #(
        .LOCK_STABLE_CYCLES (L),
        .RST_HOLD_CYCLES    (H),
        .FLUSH_CYCLES       (F)
    ) dut (
        .i_pdata_clk  (clk),
        .i_rst        (rst),
        .i_pll_locked (lock),
        .i_link_en    (en),
        .io_link      (u_if),
        .o_serdes_rst (srst),
        .o_link_up    (link),
        .o_state      (st)
    );

    int n_chk = 0;
    int n_err = 0;

    bit q_sync[$];
    int m_phase;
    int m_run;

    function automatic void chk(input string nm,
                                input logic [34:0] act,
                                input logic [34:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    function automatic int lim(input int ph);
        return (ph == 0) ? L : (ph == 1) ? H : F;
    endfunction

    // Model: the link is a sequence of phases, each lasting a fixed
    // number of uninterrupted "go" edges; lock is seen 2 edges late.
    task automatic tick();
        bit         ls;
        bit         go;
        bit         pass;
        int         prev;
        logic [9:0] e0, e1, e2;
        logic [34:0] expv, actv;
        @(posedge clk);
        prev = m_phase;
        if (rst) begin
            q_sync  = '{1'b0, 1'b0};
            m_phase = 0;
            m_run   = 0;
        end else begin
            ls = q_sync.pop_front();
            q_sync.push_back(lock);
            go = ls && en;
            if (!go) begin
                m_phase = 0;
                m_run   = 0;
            end else if (m_phase < 3) begin
                m_run++;
                if (m_run == lim(m_phase)) begin
                    m_phase++;
                    m_run = 0;
                end
            end
        end
        pass = !rst && prev == 3 && m_phase == 3;
        e0 = pass ? u_if.i_tmds_ch0 : CTRL_00;
        e1 = pass ? u_if.i_tmds_ch1 : CTRL_00;
        e2 = pass ? u_if.i_tmds_ch2 : CTRL_00;
        #1;
        expv = {m_phase < 2, m_phase == 3, m_phase == 3,
                2'(m_phase), e0, e1, e2};
        actv = {srst, link, u_if.o_timing_en, st,
                u_if.o_pdata_ch0, u_if.o_pdata_ch1, u_if.o_pdata_ch2};
        chk("model", actv, expv);
    endtask

    task automatic wait_for(input int sel, output int n);
        for (int k = 1; k <= 200; k++) begin
            tick();
            if ((sel == 0 && link === 1'b1) ||
                (sel == 1 && st === 2'd1)) begin
                n = k;
                return;
            end
        end
        n = -1;
    endtask

    function automatic logic [34:0] rst_vec();
        return {srst, link, u_if.o_timing_en, st,
                u_if.o_pdata_ch0, u_if.o_pdata_ch1, u_if.o_pdata_ch2};
    endfunction

    localparam logic [34:0] RST_EXP =
        {1'b1, 1'b0, 1'b0, 2'd0, CTRL_00, CTRL_00, CTRL_00};

    typedef struct {
        logic       rst;
        logic       lock;
        logic       en;
        int         n;
        logic [1:0] st;
        logic       srst;
        logic       link;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int n;
        rst  = 1'b1;
        lock = 1'b0;
        en   = 1'b0;
        u_if.i_tmds_ch0 = '0;
        u_if.i_tmds_ch1 = '0;
        u_if.i_tmds_ch2 = '0;
        q_sync  = '{1'b0, 1'b0};
        m_phase = 0;
        m_run   = 0;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 2,     2'd0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 2+L-1, 2'd0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1,     2'd1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, H-1,   2'd1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1,     2'd2, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, F-1,   2'd2, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1,     2'd3, 1'b0, 1'b1};

        for (int i = 0; i < 7; i++) begin
            rst  = tbl[i].rst;
            lock = tbl[i].lock;
            en   = tbl[i].en;
            repeat (tbl[i].n) tick();
            chk($sformatf("tbl%0d", i),
                35'({st, srst, link}),
                35'({tbl[i].st, tbl[i].srst, tbl[i].link}));
        end

        u_if.i_tmds_ch0 = 10'h2AA;
        tick();
        chk("pass_2aa", 35'(u_if.o_pdata_ch0), 35'(10'h2AA));
        u_if.i_tmds_ch0 = 10'h155;
        tick();
        chk("pass_155", 35'(u_if.o_pdata_ch0), 35'(10'h155));

        lock = 1'b0;
        tick();
        lock = 1'b1;
        tick();
        tick();
        chk("drop_teardown", rst_vec(), RST_EXP);
        wait_for(0, n);
        chk("drop_requal", 35'(n), 35'(L + H + F));

        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        lock = 1'b0;
        tick();
        lock = 1'b1;
        wait_for(1, n);
        chk("glitch_requal", 35'(n), 35'(10));

        repeat (H) tick();
        chk("in_flush", 35'(st), 35'(2'd2));
        repeat (F - 1) tick();
        en = 1'b0;
        tick();
        chk("flush_term_drop", rst_vec(), RST_EXP);
        en = 1'b1;

        wait_for(1, n);
        chk("reach_hold", 35'(n > 0), 35'(1));
        tick();
        rst = 1'b1;
        tick();
        chk("rst_in_hold", rst_vec(), RST_EXP);
        rst = 1'b0;
        wait_for(0, n);
        chk("reach_active", 35'(n > 0), 35'(1));
        tick();
        rst = 1'b1;
        tick();
        chk("rst_in_active", rst_vec(), RST_EXP);
        rst = 1'b0;

        for (int i = 0; i < 1500; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            lock = ($urandom_range(0, 199) != 0);
            en   = ($urandom_range(0, 199) != 0);
            u_if.i_tmds_ch0 = 10'($urandom);
            u_if.i_tmds_ch1 = 10'($urandom);
            u_if.i_tmds_ch2 = 10'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
